asic_padcfg_ctrl: RTL and testbench



---
 rtl/asic_padcfg_pkg.sv | 24 ++
 rtl/asic_padcfg_arb.sv | 37 +++
 rtl/asic_padcfg_ctrl.sv | 179 +++++++++++++++++
 tb/tb_asic_padcfg_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/asic_padcfg_pkg.sv
// rtl/asic_padcfg_pkg.sv - shared types and address field layout for the pad configuration sequencer
package asic_padcfg_pkg;

    typedef enum logic [1:0] {
        SIDE_NO = 2'd0,
        SIDE_SO = 2'd1,
        SIDE_EA = 2'd2,
        SIDE_WE = 2'd3
    } side_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUIESCE = 2'd1,
        ST_WRITE   = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    localparam int ADDR_W   = 6;
    localparam int PAD_W    = 4;
    localparam int PAD_LSB  = 0;
    localparam int SIDE_W   = 2;
    localparam int SIDE_LSB = 4;

endpackage

// File: rtl/asic_padcfg_arb.sv
// rtl/asic_padcfg_arb.sv - two-requester round-robin arbiter producing a one-hot grant
module asic_padcfg_arb (
    input  logic       clk,
    input  logic       nreset,
    input  logic       en,
    input  logic       a_valid,
    input  logic       b_valid,
    output logic [1:0] grant
);

    // 0 = A has priority on contention, 1 = B
    logic ptr_q;

    // Grant only while the sequencer can accept; pointer breaks ties
    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (a_valid && b_valid) begin
                grant = ptr_q ? 2'b10 : 2'b01;
            end else if (a_valid) begin
                grant = 2'b01;
            end else if (b_valid) begin
                grant = 2'b10;
            end
        end
    end

    // Pointer moves to the other requester after every grant
    always_ff @(posedge clk) begin
        if (!nreset) begin
            ptr_q <= 1'b0;
        end else if (|grant) begin
            ptr_q <= grant[0];
        end
    end

endmodule

// File: rtl/asic_padcfg_ctrl.sv
// rtl/asic_padcfg_ctrl.sv - padring config sequencer; PADCFG_QUIESCE_EN enables the driver quiesce/release phases
module asic_padcfg_ctrl
    import asic_padcfg_pkg::*;
#(
    parameter int NPADS  = 9,
    parameter int CFGW   = 8,
    parameter int SETTLE = 4
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [ADDR_W-1:0]     a_addr,
    input  logic [CFGW-1:0]       a_wdata,
    output logic                  a_done,
    output logic                  a_err,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [ADDR_W-1:0]     b_addr,
    input  logic [CFGW-1:0]       b_wdata,
    output logic                  b_done,
    output logic                  b_err,
    input  logic [4*NPADS-1:0]    core_oen,
    output logic [4*NPADS-1:0]    pad_oen,
    output logic [NPADS*CFGW-1:0] no_cfg,
    output logic [NPADS*CFGW-1:0] so_cfg,
    output logic [NPADS*CFGW-1:0] ea_cfg,
    output logic [NPADS*CFGW-1:0] we_cfg
);

    state_e                      state_q, state_d;
    logic [1:0]                  grant;
    logic                        accept, acc_bad, finish;
    logic [ADDR_W-1:0]           sel_addr;
    logic [CFGW-1:0]             sel_wdata;
    logic [SIDE_W-1:0]           req_side_q;
    logic [PAD_W-1:0]            req_pad_q;
    logic [CFGW-1:0]             req_wdata_q;
    logic                        req_id_q;
    logic [3:0][NPADS*CFGW-1:0]  cfg_q;
    logic                        a_done_q, a_err_q, b_done_q, b_err_q;
    logic [4*NPADS-1:0]          mask;

    asic_padcfg_arb u_arb (
        .clk     (clk),
        .nreset  (nreset),
        .en      (state_q == ST_IDLE),
        .a_valid (a_valid),
        .b_valid (b_valid),
        .grant   (grant)
    );

    assign a_ready   = grant[0];
    assign b_ready   = grant[1];
    assign accept    = |grant;
    assign sel_addr  = grant[1] ? b_addr : a_addr;
    assign sel_wdata = grant[1] ? b_wdata : a_wdata;
    assign acc_bad   = sel_addr[PAD_LSB +: PAD_W] >= PAD_W'(NPADS);

`ifdef PADCFG_QUIESCE_EN
    localparam int CNT_W = $clog2(SETTLE + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_last;

    assign cnt_last = (cnt_q == CNT_W'(SETTLE - 1));
    assign finish   = (state_q == ST_RELEASE) && cnt_last;

    // Settle counter restarts on every state change
    always_ff @(posedge clk) begin
        if (!nreset || (state_q != state_d)) begin
            cnt_q <= '0;
        end else if (state_q == ST_QUIESCE || state_q == ST_RELEASE) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Force the target pad's driver off for the whole sequence
    always_comb begin
        mask = '0;
        for (int i = 0; i < 4 * NPADS; i++) begin
            if (state_q != ST_IDLE &&
                i == int'(req_side_q) * NPADS + int'(req_pad_q)) begin
                mask[i] = 1'b1;
            end
        end
    end
`else
    assign finish = (state_q == ST_WRITE);
    assign mask   = '0;
`endif

    assign pad_oen = core_oen | mask;

    // State register
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: invalid addresses never leave IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && !acc_bad) begin
`ifdef PADCFG_QUIESCE_EN
                    state_d = ST_QUIESCE;
`else
                    state_d = ST_WRITE;
`endif
                end
            end
`ifdef PADCFG_QUIESCE_EN
            ST_QUIESCE: if (cnt_last) state_d = ST_WRITE;
            ST_WRITE:   state_d = ST_RELEASE;
            ST_RELEASE: if (cnt_last) state_d = ST_IDLE;
`else
            ST_WRITE:   state_d = ST_IDLE;
`endif
            default:    state_d = ST_IDLE;
        endcase
    end

    // Request latch, config banks and completion pulses
    always_ff @(posedge clk) begin
        if (!nreset) begin
            req_side_q  <= '0;
            req_pad_q   <= '0;
            req_wdata_q <= '0;
            req_id_q    <= 1'b0;
            cfg_q       <= '0;
            a_done_q    <= 1'b0;
            a_err_q     <= 1'b0;
            b_done_q    <= 1'b0;
            b_err_q     <= 1'b0;
        end else begin
            a_done_q <= 1'b0;
            a_err_q  <= 1'b0;
            b_done_q <= 1'b0;
            b_err_q  <= 1'b0;
            if (accept) begin
                req_side_q  <= sel_addr[SIDE_LSB +: SIDE_W];
                req_pad_q   <= sel_addr[PAD_LSB +: PAD_W];
                req_wdata_q <= sel_wdata;
                req_id_q    <= grant[1];
                if (acc_bad) begin
                    a_done_q <= grant[0];
                    a_err_q  <= grant[0];
                    b_done_q <= grant[1];
                    b_err_q  <= grant[1];
                end
            end
            if (state_q == ST_WRITE) begin
                for (int p = 0; p < NPADS; p++) begin
                    if (req_pad_q == PAD_W'(p)) begin
                        cfg_q[req_side_q][p*CFGW +: CFGW] <= req_wdata_q;
                    end
                end
            end
            if (finish) begin
                a_done_q <= !req_id_q;
                b_done_q <= req_id_q;
            end
        end
    end

    assign a_done = a_done_q;
    assign a_err  = a_err_q;
    assign b_done = b_done_q;
    assign b_err  = b_err_q;
    assign no_cfg = cfg_q[SIDE_NO];
    assign so_cfg = cfg_q[SIDE_SO];
    assign ea_cfg = cfg_q[SIDE_EA];
    assign we_cfg = cfg_q[SIDE_WE];

endmodule

// File: tb/tb_asic_padcfg_ctrl.sv
// tb/tb_asic_padcfg_ctrl.sv - directed self-checking bench for asic_padcfg_ctrl
module tb_asic_padcfg_ctrl;

    localparam int NPADS = 9;
    localparam int CFGW  = 8;
    localparam int S     = 4;
`ifdef PADCFG_QUIESCE_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif
    localparam int DONE_N    = QEN ? 2*S+2 : 2;
    localparam int VIS_N     = QEN ? S+2 : 2;
    localparam int MASK_LAST = QEN ? 2*S+1 : 0;

    logic                  clk = 1'b0;
    logic                  nreset;
    logic                  a_valid, b_valid;
    logic                  a_ready, b_ready;
    logic [5:0]            a_addr, b_addr;
    logic [CFGW-1:0]       a_wdata, b_wdata;
    logic                  a_done, b_done, a_err, b_err;
    logic [4*NPADS-1:0]    core_oen, pad_oen;
    logic [NPADS*CFGW-1:0] no_cfg, so_cfg, ea_cfg, we_cfg;

    int n_assert = 0;
    int n_fail   = 0;

    asic_padcfg_ctrl dut (
        .clk      (clk),
        .nreset   (nreset),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_done   (a_done),
        .a_err    (a_err),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_done   (b_done),
        .b_err    (b_err),
        .core_oen (core_oen),
        .pad_oen  (pad_oen),
        .no_cfg   (no_cfg),
        .so_cfg   (so_cfg),
        .ea_cfg   (ea_cfg),
        .we_cfg   (we_cfg)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        nreset  = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_addr  = '0;
        b_addr  = '0;
        a_wdata = '0;
        b_wdata = '0;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
    endtask

    // Leaves the caller at the negedge of cycle T+1
    task automatic accept_a(input logic [5:0] addr, input logic [7:0] d);
        @(negedge clk);
        a_addr  = addr;
        a_wdata = d;
        a_valid = 1'b1;
        #1;
        n_assert++;
        if (a_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_ready addr=%h got=%b exp=1", addr, a_ready);
        end
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic test_reset();
        core_oen = 36'h0_0000_0001;
        do_reset();
        @(negedge clk);
        n_assert++;
        if (pad_oen !== 36'h0_0000_0001) begin
            n_fail++;
            $display("FAIL reset_pad_oen got=%h exp=%h", pad_oen, 36'h1);
        end
        n_assert++;
        if ((no_cfg | so_cfg | ea_cfg | we_cfg) !== '0) begin
            n_fail++;
            $display("FAIL reset_cfg got=%h/%h/%h/%h exp=0", no_cfg, so_cfg, ea_cfg, we_cfg);
        end
        n_assert++;
        if ({a_ready, b_ready, a_done, b_done, a_err, b_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags got=%b exp=000000",
                     {a_ready, b_ready, a_done, b_done, a_err, b_err});
        end
    endtask

    task automatic test_single_write();
        logic [35:0] exp_oen;
        logic [7:0]  exp_cfg;
        do_reset();
        core_oen = '0;
        accept_a(6'h13, 8'hA5);
        for (int n = 1; n <= DONE_N + 1; n++) begin
            exp_oen = (n <= MASK_LAST) ? 36'h0_0000_1000 : 36'h0;
            exp_cfg = (n >= VIS_N) ? 8'hA5 : 8'h00;
            n_assert++;
            if (pad_oen !== exp_oen) begin
                n_fail++;
                $display("FAIL single_mask n=%0d got=%h exp=%h", n, pad_oen, exp_oen);
            end
            n_assert++;
            if (so_cfg[31:24] !== exp_cfg) begin
                n_fail++;
                $display("FAIL single_cfg n=%0d got=%h exp=%h", n, so_cfg[31:24], exp_cfg);
            end
            n_assert++;
            if ({a_done, a_err, b_done} !== {(n == DONE_N), 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL single_done n=%0d got=%b exp=%b", n,
                         {a_done, a_err, b_done}, {(n == DONE_N), 2'b00});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_contention();
        int  k;
        bit  a_seen;
        do_reset();
        core_oen = '0;
        @(negedge clk);
        a_valid = 1'b1; a_addr = 6'h00; a_wdata = 8'h11;
        b_valid = 1'b1; b_addr = 6'h01; b_wdata = 8'h22;
        #1;
        n_assert++;
        if ({a_ready, b_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL contend_first got=%b exp=10", {a_ready, b_ready});
        end
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        k = 1;
        while (a_done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_assert++;
        if (k != DONE_N || b_done !== 1'b0) begin
            n_fail++;
            $display("FAIL contend_a_done got=cycle%0d b_done=%b exp=cycle%0d b_done=0", k, b_done, DONE_N);
        end
        a_valid = 1'b1; a_addr = 6'h02; a_wdata = 8'h33;
        #1;
        n_assert++;
        if ({a_ready, b_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL contend_second got=%b exp=01", {a_ready, b_ready});
        end
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
        k = 1;
        a_seen = 1'b0;
        while (b_done !== 1'b1 && k < 40) begin
            if (a_done === 1'b1) a_seen = 1'b1;
            @(negedge clk);
            k++;
        end
        n_assert++;
        if (k != DONE_N || a_seen || b_err !== 1'b0) begin
            n_fail++;
            $display("FAIL contend_b_done got=cycle%0d a_seen=%b err=%b exp=cycle%0d a_seen=0 err=0",
                     k, a_seen, b_err, DONE_N);
        end
        n_assert++;
        if (no_cfg[23:0] !== 24'h00_22_11) begin
            n_fail++;
            $display("FAIL contend_cfg got=%h exp=002211", no_cfg[23:0]);
        end
    endtask

    task automatic test_invalid_pad();
        do_reset();
        core_oen = 36'h0_0000_0005;
        @(negedge clk);
        b_valid = 1'b1; b_addr = 6'h0C; b_wdata = 8'hFF;
        #1;
        n_assert++;
        if (b_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL invalid_ready got=%b exp=1", b_ready);
        end
        @(posedge clk);
        @(negedge clk);
        b_valid = 1'b0;
        n_assert++;
        if ({b_done, b_err, a_done} !== 3'b110) begin
            n_fail++;
            $display("FAIL invalid_done got=%b exp=110", {b_done, b_err, a_done});
        end
        for (int n = 1; n <= 4; n++) begin
            n_assert++;
            if (pad_oen !== 36'h0_0000_0005 || (no_cfg | so_cfg | ea_cfg | we_cfg) !== '0) begin
                n_fail++;
                $display("FAIL invalid_nochange n=%0d got=%h exp=%h", n, pad_oen, 36'h5);
            end
            @(negedge clk);
        end
        n_assert++;
        if (b_done !== 1'b0) begin
            n_fail++;
            $display("FAIL invalid_single_pulse got=%b exp=0", b_done);
        end
    endtask

    task automatic test_mid_reset();
        bit done_seen;
        do_reset();
        core_oen = 36'h0_0000_0003;
        accept_a(6'h13, 8'h77);
        @(negedge clk);
        @(negedge clk);
        nreset = 1'b0;
        @(negedge clk);
        n_assert++;
        if (pad_oen !== 36'h0_0000_0003 || so_cfg !== '0 || a_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_state got=oen %h cfg %h done %b exp=oen 3 cfg 0 done 0",
                     pad_oen, so_cfg, a_done);
        end
        nreset = 1'b1;
        done_seen = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (a_done !== 1'b0 || so_cfg !== '0) done_seen = 1'b1;
        end
        n_assert++;
        if (done_seen) begin
            n_fail++;
            $display("FAIL midreset_no_done got=1 exp=0");
        end
    endtask

    task automatic test_we_side();
        logic [35:0] exp_oen;
        do_reset();
        core_oen = '0;
        accept_a(6'h3F, 8'hEE);
        n_assert++;
        if ({a_done, a_err} !== 2'b11 || pad_oen !== '0) begin
            n_fail++;
            $display("FAIL we_err got=%b oen=%h exp=11 oen=0", {a_done, a_err}, pad_oen);
        end
        accept_a(6'h38, 8'h5A);
        for (int n = 1; n <= DONE_N; n++) begin
            exp_oen = (n <= MASK_LAST) ? 36'h8_0000_0000 : 36'h0;
            n_assert++;
            if (pad_oen !== exp_oen) begin
                n_fail++;
                $display("FAIL we_mask n=%0d got=%h exp=%h", n, pad_oen, exp_oen);
            end
            n_assert++;
            if (we_cfg[71:64] !== ((n >= VIS_N) ? 8'h5A : 8'h00)) begin
                n_fail++;
                $display("FAIL we_cfg n=%0d got=%h", n, we_cfg[71:64]);
            end
            n_assert++;
            if ({a_done, a_err} !== {(n == DONE_N), 1'b0}) begin
                n_fail++;
                $display("FAIL we_done n=%0d got=%b exp=%b", n, {a_done, a_err}, {(n == DONE_N), 1'b0});
            end
            @(negedge clk);
        end
        n_assert++;
        if (we_cfg[63:0] !== '0) begin
            n_fail++;
            $display("FAIL we_other_pads got=%h exp=0", we_cfg[63:0]);
        end
    endtask

    initial begin
        nreset   = 1'b0;
        a_valid  = 1'b0;
        b_valid  = 1'b0;
        a_addr   = '0;
        b_addr   = '0;
        a_wdata  = '0;
        b_wdata  = '0;
        core_oen = '0;
        test_reset();
        test_single_write();
        test_contention();
        test_invalid_pad();
        test_mid_reset();
        test_we_side();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
